addsub_tr: RTL and testbench

//  Parametrised, time-redundant two's-complement add/subtract unit with valid/ready handshakes.

---
 rtl/addsub_tr.sv | 124 ++++++++++++
 tb/tb_addsub_tr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/addsub_tr.sv
// Time-redundant add/subtract: each op runs true then complemented on one ripple adder, retried on mismatch.
// Latency: out_valid after 3 cycles from accept, plus 3 per retry (worst 3*(RETRY_MAX+1)).
// Backpressure: accepts only in IDLE; result held in DONE until out_ready, in_valid ignored meanwhile.
module addsub_tr #(
  parameter int WIDTH     = 8,
  parameter int RETRY_MAX = 2,
  localparam int RW       = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [WIDTH-1:0] inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             err,
  output logic [RW-1:0]    n_retry
);

  typedef enum logic [2:0] {IDLE, P1, P2, CMP, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub;
  logic [RW-1:0]    retry;
  // Result records are {cout, ovf, sum}
  logic [WIDTH+1:0] r1, r2;

  logic [WIDTH-1:0] b_int, add_x, add_y, raw, raw_inj;
  logic             add_c, c_msb, c_out;
  logic             match, can_retry;

  assign b_int     = op_sub ? ~op_b : op_b;
  // Pass 2 drives every adder line with the opposite polarity of pass 1
  assign add_x     = (state == P2) ? ~op_a  : op_a;
  assign add_y     = (state == P2) ? ~b_int : b_int;
  assign add_c     = (state == P2) ? ~op_sub : op_sub;
  assign raw_inj   = raw | inj_mask;
  assign match     = (r1 == r2);
  assign can_retry = (retry < RW'(RETRY_MAX));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Shared ripple-carry adder, exposing carry into and out of the MSB
  always_comb begin
    logic c;
    c     = add_c;
    raw   = '0;
    c_msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb = c;
      raw[i] = add_x[i] ^ add_y[i] ^ c;
      c      = (add_x[i] & add_y[i]) | (c & (add_x[i] ^ add_y[i]));
    end
    c_out = c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = P1;
      P1:   state_nxt = P2;
      P2:   state_nxt = CMP;
      CMP:  state_nxt = (!match && can_retry) ? P1 : DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, pass results, retry count and held outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_sub  <= 1'b0;
      retry   <= '0;
      r1      <= '0;
      r2      <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      n_retry <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a   <= a;
          op_b   <= b;
          op_sub <= sub;
          retry  <= '0;
        end
        P1: r1 <= {c_out, c_msb ^ c_out, raw_inj};
        // Re-invert the complemented pass; the two MSB carries flip together so ovf is unchanged
        P2: r2 <= {~c_out, c_msb ^ c_out, ~raw_inj};
        CMP: begin
          if (!match && can_retry) begin
            retry <= retry + RW'(1);
          end else begin
            {cout, ovf, sum} <= r1;
            err              <= !match;
            n_retry          <= retry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_tr.sv
// Directed bench for addsub_tr: vector table for arithmetic, hand sequences for retry, stall and reset.
// Checks latency in cycles from the accepting edge to out_valid.
// Drives inputs #1 after rising edges and samples there too.
module tb_addsub_tr;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, err;
  logic [7:0] a, b, inj_mask, sum;
  logic [1:0] n_retry;

  int checks = 0;
  int errors = 0;
  int lat;

  addsub_tr #(.WIDTH(8), .RETRY_MAX(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .inj_mask(inj_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .err(err), .n_retry(n_retry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout, e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op; inj_first applies in the first P1 cycle, inj_rest afterwards. Leaves DUT in DONE (or times out).
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vsub,
                       input logic [7:0] inj_first, input logic [7:0] inj_rest);
    a = va; b = vb; sub = vsub; inj_mask = inj_first; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      inj_mask = inj_rest;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid not seen within 20 cycles");
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_cout_ovf_err"}, 32'({cout, ovf, err}), 32'd0);
    chk({tag, "_n_retry"}, 32'(n_retry), 32'd0);
  endtask

  initial begin
    vec_t vt[8];
    logic [7:0] held_sum;
    bit seen;
    vt[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[1] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[2] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; inj_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_cleared("reset");

    // Fault-free arithmetic table
    for (int i = 0; i < 8; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].sub, 8'h00, 8'h00);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vt[i].e_sum));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vt[i].e_cout));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
      chk($sformatf("v%0d_nretry", i), 32'(n_retry), 32'd0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      release_result();
    end

    // Persistent stuck-at-1 on bit 0: every retry mismatches
    issue(8'h00, 8'h00, 1'b0, 8'h01, 8'h01);
    inj_mask = 8'h00;
    chk("perm_err", 32'(err), 32'd1);
    chk("perm_sum", 32'(sum), 32'h01);
    chk("perm_nretry", 32'(n_retry), 32'd2);
    chk("perm_latency", 32'(lat), 32'd9);
    release_result();

    // Transient fault only in the first P1 cycle: one retry recovers
    issue(8'h00, 8'h00, 1'b0, 8'h01, 8'h00);
    chk("trans_err", 32'(err), 32'd0);
    chk("trans_sum", 32'(sum), 32'h00);
    chk("trans_nretry", 32'(n_retry), 32'd1);
    chk("trans_latency", 32'(lat), 32'd6);
    release_result();

    // Stall in DONE with a competing request held on the input
    issue(8'h12, 8'h34, 1'b0, 8'h00, 8'h00);
    chk("stall_sum0", 32'(sum), 32'h46);
    held_sum = sum;
    a = 8'hAA; b = 8'h11; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_sum", i), 32'(sum), 32'(held_sum));
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("stall_rel_in_ready", 32'(in_ready), 32'd1);
    chk("stall_rel_out_valid", 32'(out_valid), 32'd0);
    chk("stall_rel_sum_kept", 32'(sum), 32'h46);

    // Reset during P2 aborts the op
    a = 8'h7F; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;          // accepted, now P1
    in_valid = 1'b0;
    @(posedge clk); #1;          // now P2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cleared("midrst");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);

    // Unit still works after the abort
    issue(8'h05, 8'h07, 1'b1, 8'h00, 8'h00);
    chk("post_sum", 32'(sum), 32'hFE);
    chk("post_latency", 32'(lat), 32'd3);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
